// File: rtl/stopwatch_lap_timer.sv
// stopwatch_lap_timer: parametrised BCD stopwatch with up/down count, IDLE/RUN/PAUSE/DONE FSM and lap FIFO.
// Optional split-time laps under `define LAP_SPLIT_EN.
module stopwatch_lap_timer #(
  parameter int          FRAC_DIGITS = 1,
  parameter logic [7:0]  MM_MAX      = 8'h59,
  parameter int          LAP_DEPTH   = 4,
  parameter int          LAP_AW      = 2,
  localparam int         FW          = 4 * FRAC_DIGITS,
  localparam int         TW          = 16 + FW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          ci,
  input  logic          start,
  input  logic          stop,
  input  logic          lap,
  input  logic          down,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic [FW-1:0] q_frac,
  output logic [7:0]    q_ss,
  output logic [7:0]    q_mm,
  output logic          running,
  output logic          co,
  input  logic          lap_rd,
  output logic [TW-1:0] lap_q,
  output logic          lap_valid,
  output logic          lap_full,
  output logic          lap_ovf
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  function automatic logic [7:0] bcd_inc(input logic [7:0] b);
    return (b[3:0] == 4'd9) ? {b[7:4] + 4'd1, 4'd0} : b + 8'd1;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] b);
    return (b[3:0] == 4'd0) ? {b[7:4] - 4'd1, 4'd9} : b - 8'd1;
  endfunction

  // Returns {carry_out_of_mm, next_time}; carry marks the MM_MAX:59:9..9 wrap.
  function automatic logic [TW:0] step_up(input logic [TW-1:0] t);
    logic [TW-1:0] r;
    logic c;
    r = t;
    c = 1'b1;
    for (int i = 0; i < FRAC_DIGITS; i++)
      if (c) begin
        c = (t[4*i+:4] == 4'd9);
        r[4*i+:4] = c ? 4'd0 : t[4*i+:4] + 4'd1;
      end
    if (c) begin
      c = (t[FW+:8] == 8'h59);
      r[FW+:8] = c ? 8'h00 : bcd_inc(t[FW+:8]);
    end
    if (c) begin
      c = (t[FW+8+:8] == MM_MAX);
      r[FW+8+:8] = c ? 8'h00 : bcd_inc(t[FW+8+:8]);
    end
    return {c, r};
  endfunction

  function automatic logic [TW-1:0] step_dn(input logic [TW-1:0] t);
    logic [TW-1:0] r;
    logic b;
    r = t;
    b = 1'b1;
    for (int i = 0; i < FRAC_DIGITS; i++)
      if (b) begin
        b = (t[4*i+:4] == 4'd0);
        r[4*i+:4] = b ? 4'd9 : t[4*i+:4] - 4'd1;
      end
    if (b) begin
      b = (t[FW+:8] == 8'h00);
      r[FW+:8] = b ? 8'h59 : bcd_dec(t[FW+:8]);
    end
    if (b)
      r[FW+8+:8] = (t[FW+8+:8] == 8'h00) ? MM_MAX : bcd_dec(t[FW+8+:8]);
    return r;
  endfunction

  function automatic logic legal(input logic [TW-1:0] v);
    logic ok;
    ok = (v[FW+:8] <= 8'h59) && (v[FW+8+:8] <= MM_MAX);
    for (int i = 0; i < TW / 4; i++)
      ok = ok && (v[4*i+:4] <= 4'd9);
    return ok;
  endfunction

  state_t        st_q, st_d;
  logic [TW-1:0] t_q, t_d;
  logic          dir_q, dir_d;
  logic          co_q, co_d;
  logic          run_q;
  logic          ovf_q, ovf_d;
  logic [LAP_AW:0] wp_q, rp_q;
  logic [TW-1:0] mem_q [LAP_DEPTH];
  logic [TW:0]   up_r;
  logic [TW-1:0] dn_r;
  logic          dn_zero, lap_ok, pop, push;
  logic [TW-1:0] push_val;

  assign up_r    = step_up(t_q);
  assign dn_r    = step_dn(t_q);
  assign dn_zero = (dn_r == '0) || (t_q == '0);

  always_comb begin
    st_d  = st_q;
    t_d   = t_q;
    dir_d = dir_q;
    co_d  = 1'b0;
    if ((st_q == IDLE || st_q == PAUSE) && load && legal(load_val))
      t_d = load_val;
    case (st_q)
      IDLE:
        if (start && !stop && !(down && t_q == '0)) begin
          st_d  = RUN;
          dir_d = down;
        end
      RUN:
        if (stop)
          st_d = PAUSE;
        else if (ci && dir_q) begin
          t_d  = dn_zero ? '0 : dn_r;
          co_d = dn_zero;
          st_d = dn_zero ? DONE : RUN;
        end else if (ci) begin
          t_d  = up_r[TW-1:0];
          co_d = up_r[TW];
        end
      PAUSE:
        if (stop) begin
          st_d = IDLE;
          t_d  = '0;
        end else if (start)
          st_d = RUN;
      default:
        st_d = stop ? IDLE : DONE;
    endcase
  end

  assign lap_valid = (wp_q != rp_q);
  assign lap_full  = ((wp_q - rp_q) == (LAP_AW+1)'(LAP_DEPTH));
  assign lap_q     = mem_q[rp_q[LAP_AW-1:0]];
  assign lap_ok    = lap && (st_q == RUN || st_q == PAUSE);
  assign pop       = lap_rd && lap_valid;
  assign push      = lap_ok && (!lap_full || pop);
  assign ovf_d     = (st_q == PAUSE && stop) ? 1'b0 : ovf_q | (lap_ok & lap_full & ~pop);

`ifdef LAP_SPLIT_EN
  logic [TW-1:0] sp_q, sp_d;
  logic [TW:0]   sp_up;
  assign sp_up    = step_up(sp_q);
  assign push_val = sp_q;
  // Split restarts on a fresh run and on every lap actually stored.
  assign sp_d = ((st_q == IDLE && st_d == RUN) || push) ? '0 :
                (st_q == RUN && ci && !stop) ? sp_up[TW-1:0] : sp_q;
  always_ff @(posedge clk or negedge clr)
    if (!clr)
      sp_q <= '0;
    else
      sp_q <= sp_d;
`else
  assign push_val = t_q;
`endif

  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      st_q  <= IDLE;
      t_q   <= '0;
      dir_q <= 1'b0;
      co_q  <= 1'b0;
      run_q <= 1'b0;
      ovf_q <= 1'b0;
      wp_q  <= '0;
      rp_q  <= '0;
    end else begin
      st_q  <= st_d;
      t_q   <= t_d;
      dir_q <= dir_d;
      co_q  <= co_d;
      run_q <= (st_d == RUN);
      ovf_q <= ovf_d;
      wp_q  <= wp_q + (LAP_AW+1)'(push);
      rp_q  <= rp_q + (LAP_AW+1)'(pop);
    end

  always_ff @(posedge clk)
    if (push)
      mem_q[wp_q[LAP_AW-1:0]] <= push_val;

  assign q_frac  = t_q[FW-1:0];
  assign q_ss    = t_q[FW+:8];
  assign q_mm    = t_q[FW+8+:8];
  assign running = run_q;
  assign co      = co_q;
  assign lap_ovf = ovf_q;
endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// tb_stopwatch_lap_timer: directed bench for stopwatch_lap_timer (default parameters).
module tb_stopwatch_lap_timer;
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        ci = 1'b0, start = 1'b0, stop = 1'b0, lap = 1'b0, down = 1'b0, load = 1'b0, lap_rd = 1'b0;
  logic [19:0] load_val = '0;
  logic [3:0]  q_frac;
  logic [7:0]  q_ss, q_mm;
  logic        running, co, lap_valid, lap_full, lap_ovf;
  logic [19:0] lap_q;
  logic [19:0] tm;
  logic [19:0] lap_exp [4];
  int          vectors = 0;
  int          errs = 0;

  stopwatch_lap_timer dut (
    .clk(clk), .clr(clr), .ci(ci), .start(start), .stop(stop), .lap(lap),
    .down(down), .load(load), .load_val(load_val), .q_frac(q_frac), .q_ss(q_ss),
    .q_mm(q_mm), .running(running), .co(co), .lap_rd(lap_rd), .lap_q(lap_q),
    .lap_valid(lap_valid), .lap_full(lap_full), .lap_ovf(lap_ovf)
  );

  always #5 clk = ~clk;
  assign tm = {q_mm, q_ss, q_frac};

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    ci = 1'b1;
    repeat (n) @(negedge clk);
    ci = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; @(negedge clk); stop = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1; @(negedge clk); lap = 1'b0;
  endtask

  task automatic pulse_rd();
    lap_rd = 1'b1; @(negedge clk); lap_rd = 1'b0;
  endtask

  task automatic do_load(input logic [19:0] v);
    load_val = v; load = 1'b1; @(negedge clk); load = 1'b0;
  endtask

  initial begin
`ifdef LAP_SPLIT_EN
    lap_exp = '{20'h00010, 20'h00010, 20'h00010, 20'h00010};
`else
    lap_exp = '{20'h00020, 20'h00030, 20'h00040, 20'h00050};
`endif
    #2 clr = 1'b0;
    #2;
    chk("rst_time", tm, 20'h0);
    chk("rst_running", {19'd0, running}, 20'd0);
    chk("rst_co", {19'd0, co}, 20'd0);
    chk("rst_valid", {19'd0, lap_valid}, 20'd0);
    chk("rst_full", {19'd0, lap_full}, 20'd0);
    chk("rst_ovf", {19'd0, lap_ovf}, 20'd0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);

    // 1: run to 00:12.3, capture a lap, then async clear mid-cycle
    pulse_start();
    ticks(123);
    chk("t1_run_123", tm, 20'h00123);
    chk("t1_running", {19'd0, running}, 20'd1);
    pulse_lap();
    chk("t1_lap_valid", {19'd0, lap_valid}, 20'd1);
    #2 clr = 1'b0;
    #1;
    chk("t1_clr_time", tm, 20'h0);
    chk("t1_clr_running", {19'd0, running}, 20'd0);
    chk("t1_clr_valid", {19'd0, lap_valid}, 20'd0);
    @(negedge clk);
    clr = 1'b1;
    ticks(10);
    chk("t1_idle_ci", tm, 20'h0);

    // 2: up count and wrap at 59:59.9
    pulse_start();
    ticks(10);
    chk("t2_up_10", tm, 20'h00010);
    pulse_stop();
    chk("t2_pause_running", {19'd0, running}, 20'd0);
    do_load(20'h59599);
    chk("t2_load_pause", tm, 20'h59599);
    pulse_start();
    ticks(1);
    chk("t2_wrap_time", tm, 20'h0);
    chk("t2_wrap_co", {19'd0, co}, 20'd1);
    chk("t2_wrap_running", {19'd0, running}, 20'd1);
    @(negedge clk);
    chk("t2_co_one_cycle", {19'd0, co}, 20'd0);
    pulse_stop();
    pulse_stop();
    chk("t2_idle_running", {19'd0, running}, 20'd0);

    // 3: down count to zero -> DONE
    do_load(20'h00003);
    down = 1'b1;
    pulse_start();
    down = 1'b0;
    chk("t3_running", {19'd0, running}, 20'd1);
    ticks(2);
    chk("t3_dn_2", tm, 20'h00001);
    chk("t3_no_co", {19'd0, co}, 20'd0);
    ticks(1);
    chk("t3_zero", tm, 20'h0);
    chk("t3_zero_co", {19'd0, co}, 20'd1);
    chk("t3_done_running", {19'd0, running}, 20'd0);
    ticks(5);
    chk("t3_done_hold", tm, 20'h0);
    chk("t3_done_co", {19'd0, co}, 20'd0);
    pulse_stop();
    down = 1'b1;
    pulse_start();
    down = 1'b0;
    chk("t3_down_zero_idle", {19'd0, running}, 20'd0);

    // 4: laps each second; fifth overflows; push+pop when full
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      ticks(10);
      pulse_lap();
    end
    chk("t4_full", {19'd0, lap_full}, 20'd1);
    chk("t4_no_ovf", {19'd0, lap_ovf}, 20'd0);
    ticks(10);
    pulse_lap();
    chk("t4_ovf", {19'd0, lap_ovf}, 20'd1);
    chk("t4_head", lap_q, 20'h00010);
    lap = 1'b1; lap_rd = 1'b1;
    @(negedge clk);
    lap = 1'b0; lap_rd = 1'b0;
    chk("t4_pushpop_full", {19'd0, lap_full}, 20'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t4_lap_q", lap_q, lap_exp[i]);
      pulse_rd();
    end
    chk("t4_empty", {19'd0, lap_valid}, 20'd0);
    pulse_rd();
    chk("t4_rd_empty", {19'd0, lap_valid}, 20'd0);
    chk("t4_rd_empty_full", {19'd0, lap_full}, 20'd0);

    // 5: stop with ci suppresses the tick; second stop clears
    pulse_stop();
    do_load(20'h00041);
    pulse_start();
    ticks(1);
    chk("t5_run_042", tm, 20'h00042);
    stop = 1'b1; ci = 1'b1;
    @(negedge clk);
    stop = 1'b0; ci = 1'b0;
    chk("t5_pause_time", tm, 20'h00042);
    chk("t5_pause_running", {19'd0, running}, 20'd0);
    chk("t5_ovf_sticky", {19'd0, lap_ovf}, 20'd1);
    pulse_stop();
    chk("t5_idle_time", tm, 20'h0);
    chk("t5_ovf_clr", {19'd0, lap_ovf}, 20'd0);

    // 6: load legality and load ignored in RUN
    do_load(20'h006A0);
    chk("t6_bad_ss", tm, 20'h0);
    do_load(20'h0000A);
    chk("t6_bad_frac", tm, 20'h0);
    do_load(20'h60000);
    chk("t6_bad_mm", tm, 20'h0);
    do_load(20'h05300);
    chk("t6_good", tm, 20'h05300);
    pulse_start();
    do_load(20'h01000);
    chk("t6_load_run", tm, 20'h05300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/stopwatch_lap_timer.md
Name: stopwatch_lap_timer

Overview:
Parametrised successor to the fixed 10/60/60 stopwatch counter. Provides a configurable BCD time chain (sub-second digits, minute range) with count-up and count-down modes, an explicit IDLE/RUN/PAUSE/DONE control FSM, preset load, and a lap-capture FIFO. It sits between the tick prescaler (ci) and the display/readout logic.

Parameters:
FRAC_DIGITS, 1, number of BCD sub-second digits (1 = 0.1 s, 2 = 0.01 s); ci rate must be 10^FRAC_DIGITS Hz
MM_MAX, 8'h59, BCD maximum of the minute field (legal range 8'h01..8'h99)
LAP_DEPTH, 4, lap FIFO entries; power of 2, 2..16
LAP_AW, 2, log2(LAP_DEPTH)
(derived) TW = 16 + 4*FRAC_DIGITS, packed time width {mm, ss, frac}

Ports:
clk  in  1  clock
clr  in  1  asynchronous active-low reset
ci  in  1  tick enable, one clk wide
start  in  1  start/resume pulse
stop  in  1  pause/clear pulse
lap  in  1  lap capture pulse
down  in  1  count direction (1 = down); latched on IDLE->RUN
load  in  1  preset load strobe (IDLE/PAUSE only)
load_val  in  TW  packed BCD preset
q_frac  out  4*FRAC_DIGITS  sub-second BCD digits
q_ss  out  8  seconds BCD
q_mm  out  8  minutes BCD
running  out  1  high in RUN
co  out  1  one-cycle pulse on wrap (up) or on reaching zero (down)
lap_rd  in  1  pop FIFO head
lap_q  out  TW  FIFO head (show-ahead)
lap_valid  out  1  FIFO not empty
lap_full  out  1  FIFO full
lap_ovf  out  1  sticky: lap dropped

Behaviour:
- clr low: asynchronously, all time digits 0, FSM IDLE, dir 0, co 0, FIFO empty, lap_ovf 0. All outputs registered except lap_q/lap_valid/lap_full, which are decoded from registered state.
- FSM transitions:
  - IDLE + start -> RUN; dir <= down. In down mode with time == 0, remain in IDLE.
  - RUN + stop -> PAUSE.
  - PAUSE + start -> RUN.
  - PAUSE + stop -> IDLE; time cleared to 0; lap_ovf cleared.
  - DONE + stop -> IDLE (time already 0).
  - start and stop in the same cycle: stop wins.
- Counting, in RUN only, on the clk edge with ci = 1; q reflects the new value the next cycle:
  - Up: frac digits 0-9 chained; ss 00-59; mm 00-MM_MAX. MM_MAX:59:9..9 + 1 -> all 0, co pulses, stays RUN.
  - Down: reverse borrow chain (ss 00 -> 59, mm borrows). Reaching all-zero -> co pulses, FSM goes DONE, time held at 0; further ci ignored.
- ci with stop in the same cycle: tick suppressed.
- load in IDLE/PAUSE replaces time with load_val when every digit is legal: frac digits <= 9, ss <= 8'h59, mm <= MM_MAX, BCD nibbles <= 9. An illegal load_val is ignored entirely. load in RUN/DONE is ignored.
- Lap capture, in RUN or PAUSE: lap pushes the current displayed (pre-tick) time.
  - Push when full: entry dropped, lap_ovf <= 1.
  - Push and pop in the same cycle when full: both occur, no overflow.
  - lap_rd when empty: ignored.
  - lap in IDLE/DONE: ignored.
- Entering IDLE does not flush the FIFO; only clr does.

Optional Feature:
Macro LAP_SPLIT_EN.
- Defined: a second up-counting BCD chain (same format/limits) counts on every RUN tick and clears on IDLE->RUN and on every accepted lap push. The FIFO stores the split counter's value at capture, i.e. the time since the previous lap or start, regardless of dir.
- Undefined: the FIFO stores the absolute displayed time; no split chain is synthesised.

Test Plan:
1. Run at 00:12.3, drive clr low between edges -> outputs 0, running 0, lap_valid 0 immediately; release; 10 ci ignored (IDLE).
2. Up mode (FRAC_DIGITS=1, MM_MAX=8'h59): start, 10 ci -> 00:01.0. Load 59:59.9 in PAUSE, start, 1 ci -> 00:00.0, co high exactly 1 cycle, running stays 1.
3. Down mode: load_val 20'h00003, down=1, start, 3 ci -> 00:00.0, co pulse, DONE, running 0; 5 more ci -> still 0; stop -> IDLE.
4. Up run, lap at 1.0/2.0/3.0/4.0/5.0 s (LAP_DEPTH=4) -> lap_full after 4th, lap_ovf=1 after 5th. Four lap_rd -> lap_q 20'h00010, 00020, 00030, 00040, then lap_valid 0. With LAP_SPLIT_EN: all four read 20'h00010.
5. RUN at 00:04.2, stop with ci same cycle -> PAUSE at 00:04.2; stop again -> IDLE at 00:00.0, lap_ovf 0.
6. IDLE, load with load_val ss=8'h6A -> ignored, time unchanged. load_val 20'h05300 -> 05:30.0.
